// File: rtl/risc_spm_defs.sv
// Shared encodings for the RISC stored-program machine: opcodes, FSM states,
// bus mux selects and instruction field positions.
package risc_spm_defs;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    typedef enum logic [3:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [2:0] SEL1_R0 = 3'd0;
    localparam logic [2:0] SEL1_R1 = 3'd1;
    localparam logic [2:0] SEL1_R2 = 3'd2;
    localparam logic [2:0] SEL1_R3 = 3'd3;
    localparam logic [2:0] SEL1_PC = 3'd4;

    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int SRC_MSB  = 3;
    localparam int SRC_LSB  = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the RISC-SPM: registered state, with all
// datapath controls decoded combinationally from state, instruction and Zflag.
module control_unit
    import risc_spm_defs::*;
#(
    parameter int word_size  = 8,
    parameter int op_size    = 4,
    parameter int state_size = 4,
    parameter int Sel1_size  = 3,
    parameter int Sel2_size  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 Zflag,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted
);

    logic [state_size-1:0] state_q, state_d;
    logic [op_size-1:0]    opcode;
    logic [1:0]            src, dest;
    logic [3:0]            ld_r;

    assign opcode = instruction[OP_MSB:OP_LSB];
    assign src    = instruction[SRC_MSB:SRC_LSB];
    assign dest   = instruction[DEST_MSB:DEST_LSB];

    assign Load_R0 = ld_r[0];
    assign Load_R1 = ld_r[1];
    assign Load_R2 = ld_r[2];
    assign Load_R3 = ld_r[3];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_idle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        ld_r          = 4'b0000;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Sel_Bus_1_Mux = SEL1_R0;
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_idle: state_d = S_fet1;
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_BUS1;
                Load_Add_R    = 1'b1;
                state_d       = S_fet2;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = S_dec;
            end
            S_dec: begin
                case (opcode)
                    OP_NOP: state_d = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = {1'b0, src};
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Reg_Y    = 1'b1;
                        state_d       = S_ex1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = {1'b0, src};
                        Sel_Bus_2_Mux = SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        ld_r          = 4'b0001 << dest;
                        state_d       = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = SEL1_PC;
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Add_R    = 1'b1;
                        state_d       = (opcode == OP_RD) ? S_rd1 :
                                        (opcode == OP_WR) ? S_wr1 : S_br1;
                    end
                    OP_BRZ: begin
                        if (Zflag) begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_BUS1;
                            Load_Add_R    = 1'b1;
                            state_d       = S_br1;
                        end else begin
                            // Skip over the branch-target byte
                            Inc_PC  = 1'b1;
                            state_d = S_fet1;
                        end
                    end
                    default: state_d = S_halt;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = {1'b0, dest};
                Sel_Bus_2_Mux = SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                ld_r          = 4'b0001 << dest;
                state_d       = S_fet1;
            end
            S_rd1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = S_rd2;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                ld_r          = 4'b0001 << dest;
                state_d       = S_fet1;
            end
            S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = S_wr2;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = {1'b0, src};
                write         = 1'b1;
                state_d       = S_fet1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                state_d       = S_br2;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
                state_d       = S_fet1;
            end
            S_halt: begin
                halted  = 1'b1;
                state_d = S_halt;
            end
            default: state_d = S_halt;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a cycle-by-cycle vector table of
// instruction sequences plus hand-written halt and mid-instruction reset runs.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       Zflag;
    logic       Load_R0, Load_R1, Load_R2, Load_R3;
    logic       Load_PC, Inc_PC;
    logic [2:0] Sel_Bus_1_Mux;
    logic [1:0] Sel_Bus_2_Mux;
    logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
        .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
        .Load_PC(Load_PC), .Inc_PC(Inc_PC),
        .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
        .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
        .Load_Reg_Z(Load_Reg_Z), .write(write), .halted(halted)
    );

    // ctrl layout: {R3,R2,R1,R0, PC, Inc, Sel1[2:0], Sel2[1:0], IR, AddR, Y, Z, write, halted}
    logic [16:0] ctrl;
    assign ctrl = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC,
                   Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
                   Load_Reg_Y, Load_Reg_Z, write, halted};

    function automatic logic [16:0] mk(input logic [3:0] ldr, input logic ldpc,
                                       input logic inc, input logic [2:0] s1,
                                       input logic [1:0] s2, input logic ir,
                                       input logic ar, input logic y,
                                       input logic z, input logic wr,
                                       input logic h);
        return {ldr, ldpc, inc, s1, s2, ir, ar, y, z, wr, h};
    endfunction

    typedef struct {
        logic        rst;
        logic [7:0]  instr;
        logic        z;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [7:0] i, input logic z,
                           input logic [16:0] e, input string n);
        vec_t v;
        v.rst = r; v.instr = i; v.z = z; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        checks++;
        if (ctrl !== exp) begin
            errors++;
            $display("FAIL %s: got ctrl=%b expected %b", name, ctrl, exp);
        end
    endtask

    // Drive inputs mid-cycle and compare once combinational outputs settle.
    task automatic step(input logic r, input logic [7:0] i, input logic z,
                        input string name, input logic [16:0] exp);
        @(negedge clk);
        rst = r; instruction = i; Zflag = z;
        #1;
        check(name, exp);
    endtask

    logic [16:0] IDLE, FET1, FET2, HALT;
    logic        saw_r3;

    initial begin
        IDLE = '0;
        FET1 = mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        FET2 = mk(4'b0000, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
        HALT = mk(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1);

        rst = 1'b1; instruction = 8'h00; Zflag = 1'b0;
        repeat (2) @(posedge clk);

        add_vec(1, 8'h16, 0, IDLE, "reset_idle");
        add_vec(0, 8'h16, 0, IDLE, "idle_released");
        add_vec(0, 8'h16, 0, FET1, "add_fet1");
        add_vec(0, 8'h16, 0, FET2, "add_fet2");
        add_vec(0, 8'h16, 1, mk(4'b0000, 0, 0, 3'd1, 2'd1, 0, 0, 1, 0, 0, 0), "add_dec");
        add_vec(0, 8'h16, 0, mk(4'b0100, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0), "add_ex1");
        add_vec(0, 8'h53, 0, FET1, "rd_fet1");
        add_vec(0, 8'h53, 0, FET2, "rd_fet2");
        add_vec(0, 8'h53, 0, FET1, "rd_dec");
        add_vec(0, 8'h53, 0, mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "rd_rd1");
        add_vec(0, 8'h53, 0, mk(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "rd_rd2");
        add_vec(0, 8'h60, 0, FET1, "wr_fet1");
        add_vec(0, 8'h60, 0, FET2, "wr_fet2");
        add_vec(0, 8'h60, 0, FET1, "wr_dec");
        add_vec(0, 8'h60, 0, mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "wr_wr1");
        add_vec(0, 8'h60, 0, mk(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0), "wr_wr2");
        add_vec(0, 8'h80, 0, FET1, "brz0_fet1");
        add_vec(0, 8'h80, 0, FET2, "brz0_fet2");
        add_vec(0, 8'h80, 0, mk(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0), "brz0_dec");
        add_vec(0, 8'h80, 1, FET1, "brz1_fet1");
        add_vec(0, 8'h80, 1, FET2, "brz1_fet2");
        add_vec(0, 8'h80, 1, FET1, "brz1_dec");
        add_vec(0, 8'h80, 0, mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "brz1_br1");
        add_vec(0, 8'h80, 0, mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "brz1_br2");
        add_vec(0, 8'h4D, 0, FET1, "not_fet1");
        add_vec(0, 8'h4D, 0, FET2, "not_fet2");
        add_vec(0, 8'h4D, 0, mk(4'b0010, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0), "not_dec");
        add_vec(0, 8'h70, 0, FET1, "br_fet1");
        add_vec(0, 8'h70, 0, FET2, "br_fet2");
        add_vec(0, 8'h70, 0, FET1, "br_dec");
        add_vec(0, 8'h70, 1, mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "br_br1");
        add_vec(0, 8'h70, 0, mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "br_br2");
        add_vec(0, 8'h2B, 0, FET1, "sub_fet1");
        add_vec(0, 8'h2B, 0, FET2, "sub_fet2");
        add_vec(0, 8'h2B, 0, mk(4'b0000, 0, 0, 3'd2, 2'd1, 0, 0, 1, 0, 0, 0), "sub_dec");
        add_vec(0, 8'h2B, 0, mk(4'b1000, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0), "sub_ex1");
        add_vec(0, 8'h00, 0, FET1, "nop_fet1");
        add_vec(0, 8'h00, 0, FET2, "nop_fet2");
        add_vec(0, 8'h00, 1, IDLE, "nop_dec");
        add_vec(0, 8'hF0, 0, FET1, "ill_fet1");
        add_vec(0, 8'hF0, 0, FET2, "ill_fet2");
        add_vec(0, 8'hF0, 0, IDLE, "ill_dec");

        foreach (vecs[k])
            step(vecs[k].rst, vecs[k].instr, vecs[k].z, vecs[k].name, vecs[k].exp);

        // Halt holds regardless of instruction/Zflag until reset
        for (int i = 0; i < 20; i++)
            step(0, 8'(i * 13), i[0], "halt_hold", HALT);
        step(1, 8'h00, 0, "halt_rst_edge1", HALT);
        step(1, 8'h00, 0, "halt_rst_idle", IDLE);
        step(0, 8'h00, 0, "halt_rel_idle", IDLE);
        step(0, 8'h53, 0, "halt_rel_fet1", FET1);

        // Reset asserted during S_rd1 aborts the RD before Load_R3
        saw_r3 = 1'b0;
        step(0, 8'h53, 0, "mid_fet2", FET2);
        step(0, 8'h53, 0, "mid_dec", FET1);
        saw_r3 |= Load_R3;
        step(1, 8'h53, 0, "mid_rd1", mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        saw_r3 |= Load_R3;
        step(0, 8'h53, 0, "mid_idle", IDLE);
        saw_r3 |= Load_R3;
        step(0, 8'h53, 0, "mid_refetch1", FET1);
        saw_r3 |= Load_R3;
        step(0, 8'h53, 0, "mid_refetch2", FET2);
        checks++;
        if (saw_r3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_load_r3: got Load_R3 seen=%b expected 0", saw_r3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Control unit that sequences the 8-bit RISC stored-program machine.
- Consumes the instruction word and the registered zero flag produced by the datapath.
- Drives every register load, PC increment and bus-mux select into the datapath, plus the memory write strobe.
- Registered-state FSM; outputs decode combinationally from the current state, the instruction fields and the zero flag. Each instruction runs as a fetch/decode/execute sequence of 3–5 cycles.

Parameters:
- word_size, 8, instruction/data width
- op_size, 4, opcode width (instruction[7:4])
- state_size, 4, FSM state register width
- Sel1_size, 3, Bus_1 mux select width
- Sel2_size, 2, Bus_2 mux select width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instruction  input  word_size  IR contents: [7:4] opcode, [3:2] src, [1:0] dest
- Zflag  input  1  registered ALU zero flag
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register file loads
- Load_PC  output  1  PC load from Bus_2
- Inc_PC  output  1  PC increment
- Sel_Bus_1_Mux  output  Sel1_size  0=R0, 1=R1, 2=R2, 3=R3, 4=PC
- Sel_Bus_2_Mux  output  Sel2_size  0=ALU, 1=Bus_1, 2=mem_word
- Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  output  1 each  datapath register loads
- write  output  1  memory write strobe, data = Bus_1, address = Add_R
- halted  output  1  high while in S_halt

Behaviour:
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8; 9–15 are illegal.
- States: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt.
- Reset:
  - rst sampled high at a clock edge forces S_idle, including mid-instruction.
  - In S_idle every output is 0 (selects = 0).
  - S_idle advances to S_fet1 unconditionally on the next cycle.
- Default in every state: all outputs 0 unless listed below.
- Fetch:
  - S_fet1: Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_fet2.
  - S_fet2: Sel2=mem, Load_IR, Inc_PC -> S_dec.
- S_dec, by opcode:
  - NOP: -> S_fet1, no loads.
  - ADD/SUB/AND: Sel1=src, Sel2=Bus_1, Load_Reg_Y -> S_ex1.
  - NOT: Sel1=src, Sel2=ALU, Load_Reg_Z, Load_R[dest] -> S_fet1.
  - RD/WR/BR: Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_rd1 / S_wr1 / S_br1 respectively.
  - BRZ, Zflag=1: same as BR -> S_br1.
  - BRZ, Zflag=0: Inc_PC only (skips the operand byte) -> S_fet1.
  - Illegal opcode: -> S_halt, no loads.
- S_ex1: Sel1=dest, Sel2=ALU, Load_Reg_Z, Load_R[dest] -> S_fet1.
- Read: S_rd1: Sel2=mem, Load_Add_R, Inc_PC -> S_rd2. S_rd2: Sel2=mem, Load_R[dest] -> S_fet1.
- Write: S_wr1: Sel2=mem, Load_Add_R, Inc_PC -> S_wr2. S_wr2: Sel1=src, write=1 -> S_fet1.
- Branch: S_br1: Sel2=mem, Load_Add_R -> S_br2. S_br2: Sel2=mem, Load_PC -> S_fet1.
- S_halt: halted=1, all other outputs 0, remains until rst.
- Invariants:
  - At most one Load_Rx asserted per cycle.
  - Load_PC and Inc_PC are never asserted together.
  - write is asserted only in S_wr2.
  - Unused state encodings go to S_halt.
- Cycle counts (fetch included):
  - NOP: 3
  - NOT: 3
  - ADD/SUB/AND: 4
  - BRZ not taken: 3
  - RD/WR/BR/BRZ taken: 5
- Zflag is sampled only in S_dec.
- Outputs are combinational, so there is zero-cycle latency from state to controls; the datapath acts on the next clock edge.

Decomposition:
- Shared package/include file risc_spm_defs holds:
  - opcode constants
  - state encodings
  - Bus_1 select codes (R0..R3, PC)
  - Bus_2 select codes (ALU, Bus_1, mem)
  - field positions for opcode/src/dest
- The datapath mux and ALU use the same constants.
- No sub-module is required. The state register and output decode live in one module as two always blocks.

Test Plan:
- Reset/idle: rst=1 for 2 cycles in any state -> next state S_idle, all outputs 0. After release: S_fet1 with Sel1=4, Sel2=1, Load_Add_R=1.
- ADD R1,R2 (instruction=8'h16): fet1, fet2 (Load_IR, Inc_PC), dec (Sel1=1, Load_Reg_Y), ex1 (Sel1=2, Sel2=0, Load_Reg_Z, Load_R2) -> fet1. 4 cycles total.
- RD R3 (8'h53) then WR from R0 (8'h60): RD asserts Load_R3 with Sel2=2 in S_rd2. WR asserts write=1 with Sel1=0 only in S_wr2. Each takes 5 cycles.
- BRZ (8'h80):
  - Zflag=0 -> dec asserts Inc_PC only -> fet1, 3 cycles.
  - Zflag=1 -> br1, br2 with Load_PC=1, Sel2=2 -> fet1, 5 cycles.
- Illegal opcode 8'hF0 -> S_halt, halted=1 held for 20 cycles with no loads. rst=1 -> S_idle.
- Reset mid-RD (rst asserted in S_rd1) -> S_idle next cycle, no Load_R3 ever asserted, refetch starts from S_fet1.
